// File: rtl/audio_freq_meter.sv
// Audio frequency meter: counts rising midpoint crossings of an 8-bit sample
// stream, with hysteresis, over a fixed gate window and publishes the count.
module audio_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter logic [7:0]  MID         = 8'd128,
  parameter logic [7:0]  HYST        = 8'd8,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_valid_i,
  input  logic [7:0]         sample_i,
  output logic [COUNT_W-1:0] freq_o,
  output logic               freq_valid_o,
  output logic               signal_present_o
);

  localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [8:0]        HI_THR    = {1'b0, MID} + {1'b0, HYST};
  localparam logic [8:0]        LO_THR    = {1'b0, MID} - {1'b0, HYST};
  localparam logic [COUNT_W:0]  CROSS_MAX = '1;
  localparam logic [COUNT_W-1:0] FREQ_SAT = '1;

  typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} level_e;

  level_e              level_q, level_d;
  logic [GATE_W-1:0]   gateCnt_q, gateCnt_d;
  logic [COUNT_W:0]    crossCnt_q, crossCnt_d;
  logic [COUNT_W-1:0]  freq_q, freq_d;
  logic                freqValid_q, freqValid_d;
  logic                present_q, present_d;

  logic                sampleHigh;
  logic                sampleLow;
  logic                edgeNow;
  logic                terminal;
  logic [COUNT_W:0]    crossInc;

  always_comb begin
    sampleHigh = {1'b0, sample_i} > HI_THR;
    sampleLow  = {1'b0, sample_i} < LO_THR;
    edgeNow    = sample_valid_i && (level_q == LVL_LOW) && sampleHigh;
    terminal   = (gateCnt_q == GATE_LAST);
    crossInc   = (crossCnt_q == CROSS_MAX) ? crossCnt_q
                                           : crossCnt_q + (COUNT_W+1)'(edgeNow);

    // Samples inside the hysteresis band (boundaries included) hold the level.
    level_d = level_q;
    if (sample_valid_i) begin
      if (sampleHigh) begin
        level_d = LVL_HIGH;
      end else if (sampleLow) begin
        level_d = LVL_LOW;
      end
    end

    gateCnt_d   = terminal ? '0 : gateCnt_q + GATE_W'(1);
    crossCnt_d  = crossInc;
    freq_d      = freq_q;
    present_d   = present_q;
    freqValid_d = terminal;

    // An edge in the terminal cycle is already folded into crossInc, so it
    // belongs to the closing window; the level is kept across the boundary.
    if (terminal) begin
      crossCnt_d = '0;
      freq_d     = (crossInc > {1'b0, FREQ_SAT}) ? FREQ_SAT : crossInc[COUNT_W-1:0];
      present_d  = (crossInc != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q     <= LVL_UNKNOWN;
      gateCnt_q   <= '0;
      crossCnt_q  <= '0;
      freq_q      <= '0;
      freqValid_q <= 1'b0;
      present_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      gateCnt_q   <= gateCnt_d;
      crossCnt_q  <= crossCnt_d;
      freq_q      <= freq_d;
      freqValid_q <= freqValid_d;
      present_q   <= present_d;
    end
  end

  assign freq_o           = freq_q;
  assign freq_valid_o     = freqValid_q;
  assign signal_present_o = present_q;

endmodule
